// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16-bit shift-and-add multiplier producing the low
// 16 bits of a*b (same result for unsigned and two's-complement operands).
// A single Add16 instance is the only adder; the carry-out is discarded.

// Add16: 16-bit adder, result wraps mod 2^16.
module Add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  assign out = a + b;

endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] m;
  logic [15:0] q;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] sum;
  logic [15:0] acc_next;

  // acc + M through the shared adder
  Add16 u_add (
    .a   (acc),
    .b   (m),
    .out (sum)
  );

  // Accumulator value after this iteration: add only when the current multiplier bit is set
  always_comb begin
    acc_next = acc;
    if (q[0]) begin
      acc_next = sum;
    end
  end

  // Control FSM and datapath registers; reset overrides everything including start
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          m   <= {m[14:0], 1'b0};
          q   <= {1'b0, q[15:1]};
          cnt <= cnt + 4'd1;
          // Last iteration: publish the accumulator including this edge's add
          if (cnt == 4'd15) begin
            out   <= acc_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: self-checking bench for mul16_seq against an arithmetic
// reference model (plain 32-bit multiply truncated to 16 bits).
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul16_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int unsigned p;
    p = (32'(x) * 32'(y)) % 32'd65536;
    return p[15:0];
  endfunction

  // advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one operation from accept to return to IDLE; caller is positioned just after an edge
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input bit scramble);
    int lat;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "/busy_after_accept"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      if (scramble) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      tick();
      lat++;
    end
    check({tag, "/latency"}, lat, 32'd16);
    check({tag, "/out"}, 32'(out), 32'(ref_mul(x, y)));
    tick();
    check({tag, "/busy_end"}, 32'(busy), 32'd0);
    check({tag, "/done_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    int e;
    bit seen;
    logic [15:0] rx;
    logic [15:0] ry;
    logic [15:0] vx [6];
    logic [15:0] vy [6];

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/out", 32'(out), 32'd0);

    repeat (5) begin
      tick();
      check("idle/busy", 32'(busy), 32'd0);
      check("idle/done", 32'(done), 32'd0);
      check("idle/out", 32'(out), 32'd0);
    end

    run_op("3x5", 16'd3, 16'd5, 1'b0);
    repeat (10) tick();
    check("3x5/out_hold", 32'(out), 32'd15);

    vx = '{16'd123, 16'hFFFF, 16'hFFFF, 16'd300, 16'd0, 16'h8000};
    vy = '{16'd456, 16'h0001, 16'hFFFF, 16'd300, 16'h1234, 16'h0002};
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("edge%0d", i), vx[i], vy[i], 1'b0);
    end
    run_op("lit123x456", 16'd123, 16'd456, 1'b0);
    check("lit123x456/value", 32'(out), 32'd56088);
    run_op("litm1xm1", 16'hFFFF, 16'hFFFF, 1'b0);
    check("litm1xm1/value", 32'(out), 32'h0001);

    for (int i = 0; i < 20; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      run_op($sformatf("rand%0d", i), rx, ry, 1'b0);
    end

    // starts during RUN and DONE are ignored; a held start is taken at E18
    a = 16'd7;
    b = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    while (!done && e < 40) begin
      if (e == 4) begin
        start = 1'b1;
        a = 16'd1;
        b = 16'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      e++;
    end
    check("ign/latency", e, 32'd16);
    check("ign/out", 32'(out), 32'd63);
    start = 1'b1;
    a = 16'd1;
    b = 16'd1;
    tick();
    check("ign/busy_E17", 32'(busy), 32'd0);
    check("ign/out_E17", 32'(out), 32'd63);
    tick();
    check("ign/busy_E18", 32'(busy), 32'd1);
    e = 0;
    while (!done && e < 40) begin
      tick();
      e++;
    end
    start = 1'b0;
    check("held/latency", e, 32'd16);
    check("held/out", 32'(out), 32'd1);
    tick();

    run_op("pre_abort", 16'd77, 16'd3, 1'b0);

    // reset mid-operation
    a = 16'd100;
    b = 16'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/out", 32'(out), 32'd0);
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("abort/no_activity", 32'(seen), 32'd0);
    run_op("2x2", 16'd2, 16'd2, 1'b0);

    // start and reset together: nothing accepted
    a = 16'd5;
    b = 16'd5;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("rst_start/busy", 32'(busy), 32'd0);
    check("rst_start/out", 32'(out), 32'd0);

    run_op("12x12_scramble", 16'd12, 16'd12, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      run_op($sformatf("rscr%0d", i), rx, ry, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
